// File: rtl/moore_arb_pkg.sv
// Shared definitions for the Moore round-robin arbiter: FSM state codes,
// default sizing constants and an elaboration-time clog2 helper.
package moore_arb_pkg;

    // Code 2'b11 is deliberately unused; the controller recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_MAX_HOLD = 16;

    // Number of bits needed to index 'value' distinct items.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/moore_rr_arbiter_rr_pick.sv
// Rotate-priority picker: returns the first set request bit found scanning
// ptr+1, ptr+2, ... with wrap modulo N. Purely combinational.
module rr_pick
    import moore_arb_pkg::*;
#(
    parameter int N   = DEFAULT_N,
    parameter int IDW = clog2(DEFAULT_N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] win
);

    // Scan from the farthest offset down to ptr+1 so the nearest set bit wins last.
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int k = N; k >= 1; k--) begin
            automatic int idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                any = 1'b1;
                win = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/moore_rr_arbiter.sv
// Moore round-robin arbiter placed in front of a shared FSM core.
// All outputs come from registered state; req only steers the next state.
// Optional macro HOLD_TIMEOUT_EN bounds each grant to MAX_HOLD cycles and
// pulses timeout during the GAP cycle that follows a forced revocation.
module moore_rr_arbiter
    import moore_arb_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int IDW      = clog2(DEFAULT_N),
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    state_t         state_reg, state_next;
    logic [N-1:0]   gnt_reg, gnt_next;
    logic [IDW-1:0] gnt_id_reg, gnt_id_next;
    logic [IDW-1:0] ptr_reg, ptr_next;
    logic           pick_any;
    logic [IDW-1:0] pick_win;

`ifdef HOLD_TIMEOUT_EN
    logic [7:0]     hold_reg, hold_next;
    logic           timeout_reg, timeout_next;
`endif

    // One picker serves both the IDLE and GAP exits.
    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req (req),
        .ptr (ptr_reg),
        .any (pick_any),
        .win (pick_win)
    );

    // State register; reset parks ptr on N-1 so requester 0 goes first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            gnt_reg    <= '0;
            gnt_id_reg <= IDW'(N - 1);
            ptr_reg    <= IDW'(N - 1);
`ifdef HOLD_TIMEOUT_EN
            hold_reg    <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            gnt_id_reg <= gnt_id_next;
            ptr_reg    <= ptr_next;
`ifdef HOLD_TIMEOUT_EN
            hold_reg    <= hold_next;
            timeout_reg <= timeout_next;
`endif
        end
    end

    // Next-state logic: grant is latched on the transition edge, never decoded from req.
    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        gnt_id_next = gnt_id_reg;
        ptr_next    = ptr_reg;
`ifdef HOLD_TIMEOUT_EN
        hold_next    = hold_reg;
        timeout_next = 1'b0;
`endif
        case (state_reg)
            IDLE, GAP: begin
                gnt_next = '0;
                if (pick_any) begin
                    state_next  = GRANT;
                    gnt_id_next = pick_win;
                    gnt_next    = N'(1) << pick_win;
`ifdef HOLD_TIMEOUT_EN
                    hold_next   = '0;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                // No preemption: only the owner releasing (or the hold limit) ends a grant.
                if (!req[gnt_id_reg]) begin
                    state_next = GAP;
                    gnt_next   = '0;
                    ptr_next   = gnt_id_reg;
`ifdef HOLD_TIMEOUT_EN
                end else if (hold_reg == 8'(MAX_HOLD - 1)) begin
                    state_next   = GAP;
                    gnt_next     = '0;
                    ptr_next     = gnt_id_reg;
                    timeout_next = 1'b1;
                end else begin
                    hold_next = hold_reg + 8'd1;
`endif
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    assign gnt    = gnt_reg;
    assign gnt_id = gnt_id_reg;
    assign busy   = (state_reg == GRANT);

`ifdef HOLD_TIMEOUT_EN
    assign timeout = timeout_reg;
`else
    // Grants are unbounded here; MAX_HOLD is referenced only so the parameter stays used.
    assign timeout = (MAX_HOLD < 0);
`endif

endmodule

// File: tb/tb_moore_rr_arbiter.sv
// Self-checking bench for moore_rr_arbiter: directed scenarios followed by
// random request traffic, all compared against a behavioural model.
module tb_moore_rr_arbiter;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    int tests = 0;
    int fails = 0;

    // Behavioural model: who owns the resource, whether it is held, rotation origin.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_timeout;

    always #5 clk = ~clk;

    moore_rr_arbiter #(
        .N        (N),
        .IDW      (IDW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy    = 1'b0;
        m_owner   = N - 1;
        m_ptr     = N - 1;
        m_hold    = 0;
        m_timeout = 1'b0;
    endtask

    // One clock of the arbitration rules; a free resource (idle or turnaround) picks next.
    task automatic model_step(input logic [N-1:0] r);
        m_timeout = 1'b0;
        if (m_busy) begin
            if (!r[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = m_owner;
            end
`ifdef HOLD_TIMEOUT_EN
            else if (m_hold == MAX_HOLD - 1) begin
                m_busy    = 1'b0;
                m_ptr     = m_owner;
                m_timeout = 1'b1;
            end
`endif
            else begin
                m_hold++;
            end
        end else begin
            int w;
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_hold  = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] exp_gnt;
        exp_gnt = m_busy ? (N'(1) << m_owner) : '0;
        check({tag, ".gnt"},     32'(gnt),     32'(exp_gnt));
        check({tag, ".gnt_id"},  32'(gnt_id),  32'(m_owner));
        check({tag, ".busy"},    32'(busy),    32'(m_busy));
        check({tag, ".timeout"}, 32'(timeout), 32'(m_timeout));
        check({tag, ".onehot0"}, 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic cycle(input logic [N-1:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        $display("[TB] %s req=%b gnt=%b gnt_id=%0d busy=%b timeout=%b", tag, r, gnt, gnt_id, busy, timeout);
        check_model(tag);
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        req = r;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.gnt",    32'(gnt),    32'd0);
        check("reset.busy",   32'(busy),   32'd0);
        check("reset.gnt_id", 32'(gnt_id), 32'(N - 1));
        check_model("reset");
        rst = 1'b1;
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] r;

        // Reset with all requesting: requester 0 wins first.
        do_reset(4'b1111);
        cycle(4'b1111, "first");
        check("first.gnt",    32'(gnt),    32'h1);
        check("first.gnt_id", 32'(gnt_id), 32'd0);

        // Single requester: five grant cycles, one gap, idle, then re-grant.
        do_reset(4'b0000);
        for (int i = 0; i < 5; i++) cycle(4'b0100, "single");
        check("single.gnt", 32'(gnt), 32'h4);
        cycle(4'b0000, "single_gap");
        check("single_gap.gnt", 32'(gnt), 32'h0);
        cycle(4'b0000, "single_idle");
        cycle(4'b0100, "single_again");
        check("single_again.gnt", 32'(gnt), 32'h4);

        // Round robin with everyone requesting; owners drop briefly after 3 cycles.
        do_reset(4'b1111);
        cycle(4'b1111, "rr");
        for (int g = 0; g < 5; g++) begin
            check("rr.order_id",  32'(gnt_id), 32'(exp_order[g]));
            check("rr.order_gnt", 32'(gnt),    32'(4'b0001 << exp_order[g]));
            cycle(4'b1111, "rr");
            cycle(4'b1111, "rr");
            cycle(4'b1111 & ~(4'b0001 << exp_order[g]), "rr_drop");
            check("rr.gap", 32'(gnt), 32'h0);
            cycle(4'b1111, "rr");
        end

        // Handover collision: owner 1 drops as requester 3 rises.
        do_reset(4'b0000);
        cycle(4'b0010, "handover");
        cycle(4'b0010, "handover");
        cycle(4'b1000, "handover_gap");
        check("handover.gap", 32'(gnt), 32'h0);
        cycle(4'b1000, "handover_new");
        check("handover.new", 32'(gnt), 32'h8);

        // Asynchronous reset in the middle of a grant.
        do_reset(4'b0000);
        cycle(4'b0010, "async");
        check("async.pre", 32'(gnt), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async.gnt",    32'(gnt),    32'h0);
        check("async.gnt_id", 32'(gnt_id), 32'd3);
        check("async.busy",   32'(busy),   32'd0);
        req = 4'b1111;
        #1;
        rst = 1'b1;
        cycle(4'b1111, "async_after");
        check("async_after.gnt", 32'(gnt), 32'h1);

`ifdef HOLD_TIMEOUT_EN
        // Hold limit: requester 0 is revoked after MAX_HOLD cycles in favour of 1.
        do_reset(4'b0000);
        for (int c = 1; c <= 40; c++) begin
            cycle(4'b0011, "hold");
            if (c == MAX_HOLD) check("hold.last", 32'(gnt), 32'h1);
            if (c == MAX_HOLD + 1) begin
                check("hold.gap",   32'(gnt),     32'h0);
                check("hold.pulse", 32'(timeout), 32'd1);
            end
            if (c == MAX_HOLD + 2) check("hold.next", 32'(gnt), 32'h2);
        end
`endif

        // Random traffic: bits flip occasionally so transactions last several cycles.
        do_reset(4'b0000);
        r = '0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            cycle(r, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
